pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central hazard and flow controller for the 5-stage pipeline. It generates the per-stage hold and flush (jump) controls consumed by the PC register and by the IF/ID, ID/EX and EX/MEM pipeline registers. It sequences four events:

- load-use bubbles
- multi-cycle divide stalls
- data-memory wait states
- branch/jump redirects, including a redirect that arrives while the pipeline is frozen

It also keeps stall and flush performance counters.

## Interface
Parameters:
- DIV_TIMEOUT, 64: max cycles in divide wait before forced release
- CNT_W, 32: performance counter width

Ports:
- clk_100MHz  in  1  system clock; all state updates on rising edge
- arst_n  in  1  asynchronous, active-low reset
- id_reg1_r_ena_i, id_reg2_r_ena_i  in  1  ID-stage instruction reads rs1/rs2
- id_reg1_addr_i, id_reg2_addr_i  in  5  ID-stage source register addresses
- ex_mem_r_ena_i  in  1  EX-stage instruction is a load
- ex_reg_w_ena_i  in  1  EX-stage instruction writes a register
- ex_reg_w_addr_i  in  5  EX-stage destination register
- ex_jump_ena_i  in  1  EX resolved a taken branch/jump
- ex_jump_addr_i  in  32  redirect target
- ex_div_start_i  in  1  single-cycle pulse: divide launched in EX
- div_done_i  in  1  divider result valid (1 cycle)
- mem_wait_i  in  1  data memory not ready (level)
- hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o  out  1  freeze stage (1 = hold)
- flush_if_id_o, flush_id_ex_o, flush_ex_mem_o  out  1  load bubble into stage, driven to the register's jump/flush input
- jump_ena_o  out  1  PC redirect strobe
- jump_addr_o  out  32  PC redirect target
- div_timeout_o  out  1  sticky: divide watchdog fired
- stall_cnt_o  out  CNT_W  cycles with hold_pc_o = 1
- flush_cnt_o  out  CNT_W  redirects issued

## Operation
The FSM has two states: S_RUN and S_DIV_WAIT. Auxiliary registers:
- jmp_pend, jmp_addr_q
- div_cnt (log2(DIV_TIMEOUT)+1 bits)
- the two counters
- the sticky timeout flag

Control outputs are combinational. The first matching rule applies:

1. **mem_wait_i = 1**
   - All four holds = 1; all flushes = 0; jump_ena_o = 0.
   - If ex_jump_ena_i = 1 and jmp_pend = 0: set jmp_pend, capture ex_jump_addr_i.
2. **state S_DIV_WAIT and div_done_i = 0**
   - hold_pc/if_id/id_ex = 1; flush_ex_mem_o = 1 (bubbles into MEM); hold_ex_mem_o = 0.
3. **jmp_pend = 1**
   - jump_ena_o = 1, jump_addr_o = jmp_addr_q; flush_if_id_o = flush_id_ex_o = 1.
   - Clear jmp_pend.
4. **ex_jump_ena_i = 1**
   - jump_ena_o = 1, jump_addr_o = ex_jump_addr_i; flush_if_id_o = flush_id_ex_o = 1.
5. **Load-use hazard**
   - Hazard condition: ex_mem_r_ena_i & ex_reg_w_ena_i & ex_reg_w_addr_i != 0 & ((id_reg1_r_ena_i & addr1 match) | (id_reg2_r_ena_i & addr2 match)).
   - Response: hold_pc = hold_if_id = 1; flush_id_ex_o = 1.
6. **Otherwise:** all holds and flushes = 0.

Default outputs: jump_addr_o = 0 when jump_ena_o = 0.

FSM transitions:
- **S_RUN → S_DIV_WAIT** on ex_div_start_i = 1 with mem_wait_i = 0. div_cnt is cleared.
- **S_DIV_WAIT → S_RUN** when any of the following occurs:
  - div_done_i = 1. That cycle all holds are released, so the result advances.
  - div_cnt reaches DIV_TIMEOUT-1. This sets div_timeout_o.
- div_cnt increments each S_DIV_WAIT cycle in which mem_wait_i = 0.

Counters:
- stall_cnt_o increments every cycle in which hold_pc_o = 1.
- flush_cnt_o increments every cycle in which jump_ena_o = 1.
- Both wrap modulo 2^CNT_W without saturation.

A second jump while jmp_pend = 1 is ignored; the older redirect wins.

## Timing
- Hold, flush and jump outputs are combinational, valid in the same cycle as their causing input. The pipeline registers act on them at the next edge.
- Load-use: exactly 1 bubble cycle.
- Pending jump issues in the first cycle after mem_wait_i falls.
- Divide stall length: cycles from the start pulse until div_done_i, plus mem_wait cycles. The maximum without wait states is DIV_TIMEOUT.
- Reset (arst_n = 0, asynchronous):
  - state = S_RUN; jmp_pend = 0, jmp_addr_q = 0, div_cnt = 0.
  - div_timeout_o = 0; stall_cnt_o = flush_cnt_o = 0.
  - All hold, flush and jump outputs are forced to 0 while arst_n = 0.
- Reset mid-stall or with a pending jump discards the stall or jump. Operation resumes in S_RUN at the first edge after release.

## Structure
- Shared define header additions:
  - state encodings S_RUN, S_DIV_WAIT
  - `HOLD_ENABLE` and `JUMP_ENABLE` (existing, value 1)
  - a DIV_TIMEOUT default define
- One natural sub-module, hazard_detect: a purely combinational load-use comparator. The FSM, pending-jump logic and counters stay in pipe_ctrl.

## Test plan
- **Load-use:** EX load with ex_reg_w_addr_i = 5; ID rs2 = 5, read enabled → 1 cycle of hold_pc = hold_if_id = 1 and flush_id_ex = 1; stall_cnt_o = 1. Same stimulus with address 0 → no stall.
- **Jump:** ex_jump_ena_i = 1, addr 0x0000_0100 → jump_ena_o = 1, jump_addr_o = 0x100, IF/ID and ID/EX flushed; flush_cnt_o = 1.
- **Jump during mem_wait:** mem_wait_i high 3 cycles, jump 0x200 in cycle 1 and 0x300 in cycle 2 → all holds for 3 cycles, then a single redirect to 0x200 in the next cycle.
- **Divide:** start pulse, div_done_i 10 cycles later → 10 cycles of hold_pc/if_id/id_ex with flush_ex_mem; release in the done cycle; stall_cnt_o = 10.
- **Divide timeout:** start with no done → exit after DIV_TIMEOUT cycles; div_timeout_o = 1 and stays sticky.
- **Reset and wrap:** arst_n pulsed mid-divide with jmp_pend set → all outputs 0 immediately, S_RUN afterwards. With CNT_W = 4 and 17 stall cycles → stall_cnt_o = 1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encodings and control constants for the pipeline controller
package pipe_ctrl_pkg;

    typedef enum logic {
        S_RUN      = 1'b0,
        S_DIV_WAIT = 1'b1
    } state_e;

    localparam logic HOLD_ENABLE     = 1'b1;
    localparam logic JUMP_ENABLE     = 1'b1;
    localparam int   DIV_TIMEOUT_DEF = 64;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator between the EX load and the ID sources
module hazard_detect (
    input  logic       id_reg1_r_ena_i,
    input  logic       id_reg2_r_ena_i,
    input  logic [4:0] id_reg1_addr_i,
    input  logic [4:0] id_reg2_addr_i,
    input  logic       ex_mem_r_ena_i,
    input  logic       ex_reg_w_ena_i,
    input  logic [4:0] ex_reg_w_addr_i,
    output logic       hazard_o
);

    // x0 is never a real producer, so a load targeting it cannot create a hazard
    always_comb begin
        hazard_o = ex_mem_r_ena_i && ex_reg_w_ena_i && (ex_reg_w_addr_i != 5'd0) &&
                   ((id_reg1_r_ena_i && (id_reg1_addr_i == ex_reg_w_addr_i)) ||
                    (id_reg2_r_ena_i && (id_reg2_addr_i == ex_reg_w_addr_i)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hold/flush/redirect sequencing with divide watchdog and perf counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF,
    parameter int CNT_W       = 32
) (
    input  logic             clk_100MHz,
    input  logic             arst_n,
    input  logic             id_reg1_r_ena_i,
    input  logic             id_reg2_r_ena_i,
    input  logic [4:0]       id_reg1_addr_i,
    input  logic [4:0]       id_reg2_addr_i,
    input  logic             ex_mem_r_ena_i,
    input  logic             ex_reg_w_ena_i,
    input  logic [4:0]       ex_reg_w_addr_i,
    input  logic             ex_jump_ena_i,
    input  logic [31:0]      ex_jump_addr_i,
    input  logic             ex_div_start_i,
    input  logic             div_done_i,
    input  logic             mem_wait_i,
    output logic             hold_pc_o,
    output logic             hold_if_id_o,
    output logic             hold_id_ex_o,
    output logic             hold_ex_mem_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             flush_ex_mem_o,
    output logic             jump_ena_o,
    output logic [31:0]      jump_addr_o,
    output logic             div_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int DW = $clog2(DIV_TIMEOUT) + 1;

    state_e            state_q, state_d;
    logic              jmp_pend_q, jmp_pend_d;
    logic [31:0]       jmp_addr_q, jmp_addr_d;
    logic [DW-1:0]     div_cnt_q, div_cnt_d;
    logic              div_to_q, div_to_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              load_use;
    logic              hold_pc, hold_if_id, hold_id_ex, hold_ex_mem;
    logic              flush_if_id, flush_id_ex, flush_ex_mem;
    logic              jump_ena;
    logic [31:0]       jump_addr;

    hazard_detect u_hazard (
        .id_reg1_r_ena_i (id_reg1_r_ena_i),
        .id_reg2_r_ena_i (id_reg2_r_ena_i),
        .id_reg1_addr_i  (id_reg1_addr_i),
        .id_reg2_addr_i  (id_reg2_addr_i),
        .ex_mem_r_ena_i  (ex_mem_r_ena_i),
        .ex_reg_w_ena_i  (ex_reg_w_ena_i),
        .ex_reg_w_addr_i (ex_reg_w_addr_i),
        .hazard_o        (load_use)
    );

    // Prioritised control decode; a jump seen during a memory wait is parked until the wait ends
    always_comb begin
        hold_pc      = 1'b0;
        hold_if_id   = 1'b0;
        hold_id_ex   = 1'b0;
        hold_ex_mem  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        jump_ena     = 1'b0;
        jump_addr    = 32'd0;
        jmp_pend_d   = jmp_pend_q;
        jmp_addr_d   = jmp_addr_q;
        if (mem_wait_i) begin
            hold_pc     = HOLD_ENABLE;
            hold_if_id  = HOLD_ENABLE;
            hold_id_ex  = HOLD_ENABLE;
            hold_ex_mem = HOLD_ENABLE;
            if (ex_jump_ena_i && !jmp_pend_q) begin
                jmp_pend_d = 1'b1;
                jmp_addr_d = ex_jump_addr_i;
            end
        end else if (state_q == S_DIV_WAIT && !div_done_i) begin
            hold_pc      = HOLD_ENABLE;
            hold_if_id   = HOLD_ENABLE;
            hold_id_ex   = HOLD_ENABLE;
            flush_ex_mem = 1'b1;
        end else if (jmp_pend_q) begin
            jump_ena    = JUMP_ENABLE;
            jump_addr   = jmp_addr_q;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            jmp_pend_d  = 1'b0;
        end else if (ex_jump_ena_i) begin
            jump_ena    = JUMP_ENABLE;
            jump_addr   = ex_jump_addr_i;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            hold_pc     = HOLD_ENABLE;
            hold_if_id  = HOLD_ENABLE;
            flush_id_ex = 1'b1;
        end
    end

    // Divide wait sequencing: leave on done or once the watchdog count expires
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        div_to_d  = div_to_q;
        if (state_q == S_RUN) begin
            if (ex_div_start_i && !mem_wait_i) begin
                state_d   = S_DIV_WAIT;
                div_cnt_d = '0;
            end
        end else if (div_done_i) begin
            state_d = S_RUN;
        end else if (!mem_wait_i) begin
            if (div_cnt_q == DW'(DIV_TIMEOUT - 1)) begin
                state_d  = S_RUN;
                div_to_d = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    // State, pending redirect, watchdog flag and free-running wrap counters
    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= S_RUN;
            jmp_pend_q  <= 1'b0;
            jmp_addr_q  <= 32'd0;
            div_cnt_q   <= '0;
            div_to_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            jmp_pend_q  <= jmp_pend_d;
            jmp_addr_q  <= jmp_addr_d;
            div_cnt_q   <= div_cnt_d;
            div_to_q    <= div_to_d;
            stall_cnt_q <= stall_cnt_q + CNT_W'(hold_pc);
            flush_cnt_q <= flush_cnt_q + CNT_W'(jump_ena);
        end
    end

    assign hold_pc_o      = arst_n && hold_pc;
    assign hold_if_id_o   = arst_n && hold_if_id;
    assign hold_id_ex_o   = arst_n && hold_id_ex;
    assign hold_ex_mem_o  = arst_n && hold_ex_mem;
    assign flush_if_id_o  = arst_n && flush_if_id;
    assign flush_id_ex_o  = arst_n && flush_id_ex;
    assign flush_ex_mem_o = arst_n && flush_ex_mem;
    assign jump_ena_o     = arst_n && jump_ena;
    assign jump_addr_o    = arst_n ? jump_addr : 32'd0;
    assign div_timeout_o  = div_to_q;
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

    localparam int TO    = 16;
    localparam int CNT_W = 4;

    logic        clk_100MHz = 1'b0;
    logic        arst_n     = 1'b0;
    logic        id_reg1_r_ena_i, id_reg2_r_ena_i;
    logic [4:0]  id_reg1_addr_i, id_reg2_addr_i;
    logic        ex_mem_r_ena_i, ex_reg_w_ena_i;
    logic [4:0]  ex_reg_w_addr_i;
    logic        ex_jump_ena_i;
    logic [31:0] ex_jump_addr_i;
    logic        ex_div_start_i, div_done_i, mem_wait_i;
    logic        hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o;
    logic        flush_if_id_o, flush_id_ex_o, flush_ex_mem_o;
    logic        jump_ena_o;
    logic [31:0] jump_addr_o;
    logic        div_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    bit          m_div, m_pend, m_to;
    int          m_el, m_stall, m_flush;
    logic [31:0] m_addr;

    pipe_ctrl #(.DIV_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk_100MHz      (clk_100MHz),
        .arst_n          (arst_n),
        .id_reg1_r_ena_i (id_reg1_r_ena_i),
        .id_reg2_r_ena_i (id_reg2_r_ena_i),
        .id_reg1_addr_i  (id_reg1_addr_i),
        .id_reg2_addr_i  (id_reg2_addr_i),
        .ex_mem_r_ena_i  (ex_mem_r_ena_i),
        .ex_reg_w_ena_i  (ex_reg_w_ena_i),
        .ex_reg_w_addr_i (ex_reg_w_addr_i),
        .ex_jump_ena_i   (ex_jump_ena_i),
        .ex_jump_addr_i  (ex_jump_addr_i),
        .ex_div_start_i  (ex_div_start_i),
        .div_done_i      (div_done_i),
        .mem_wait_i      (mem_wait_i),
        .hold_pc_o       (hold_pc_o),
        .hold_if_id_o    (hold_if_id_o),
        .hold_id_ex_o    (hold_id_ex_o),
        .hold_ex_mem_o   (hold_ex_mem_o),
        .flush_if_id_o   (flush_if_id_o),
        .flush_id_ex_o   (flush_id_ex_o),
        .flush_ex_mem_o  (flush_ex_mem_o),
        .jump_ena_o      (jump_ena_o),
        .jump_addr_o     (jump_addr_o),
        .div_timeout_o   (div_timeout_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        id_reg1_r_ena_i = 0; id_reg2_r_ena_i = 0;
        id_reg1_addr_i  = 0; id_reg2_addr_i  = 0;
        ex_mem_r_ena_i  = 0; ex_reg_w_ena_i  = 0; ex_reg_w_addr_i = 0;
        ex_jump_ena_i   = 0; ex_jump_addr_i  = 0;
        ex_div_start_i  = 0; div_done_i = 0; mem_wait_i = 0;
    endtask

    task automatic model_clear();
        m_div = 0; m_pend = 0; m_to = 0; m_el = 0;
        m_stall = 0; m_flush = 0; m_addr = 0;
    endtask

    // One clock: compare combinational controls mid-cycle, advance model, then compare state after edge
    task automatic cycle();
        logic [3:0]  e_h;
        logic [2:0]  e_f;
        logic        e_j, lu, div_stall;
        logic [31:0] e_a;
        @(negedge clk_100MHz);
        e_h = 0; e_f = 0; e_j = 0; e_a = 0;
        lu = ex_mem_r_ena_i && ex_reg_w_ena_i && ex_reg_w_addr_i != 0 &&
             ((id_reg1_r_ena_i && id_reg1_addr_i == ex_reg_w_addr_i) ||
              (id_reg2_r_ena_i && id_reg2_addr_i == ex_reg_w_addr_i));
        div_stall = m_div && !div_done_i;
        if (mem_wait_i) e_h = 4'b1111;
        else if (div_stall) begin e_h = 4'b1110; e_f = 3'b001; end
        else if (m_pend) begin e_j = 1; e_a = m_addr; e_f = 3'b110; end
        else if (ex_jump_ena_i) begin e_j = 1; e_a = ex_jump_addr_i; e_f = 3'b110; end
        else if (lu) begin e_h = 4'b1100; e_f = 3'b010; end
        chk("hold",  {28'd0, hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o}, {28'd0, e_h});
        chk("flush", {29'd0, flush_if_id_o, flush_id_ex_o, flush_ex_mem_o}, {29'd0, e_f});
        chk("jena",  {31'd0, jump_ena_o}, {31'd0, e_j});
        chk("jaddr", jump_addr_o, e_a);
        if (mem_wait_i) begin
            if (ex_jump_ena_i && !m_pend) begin m_pend = 1; m_addr = ex_jump_addr_i; end
        end else if (!div_stall) m_pend = 0;
        m_stall = (m_stall + int'(e_h[3])) % (1 << CNT_W);
        m_flush = (m_flush + int'(e_j)) % (1 << CNT_W);
        if (!m_div) begin
            if (ex_div_start_i && !mem_wait_i) begin m_div = 1; m_el = 0; end
        end else if (div_done_i) m_div = 0;
        else if (!mem_wait_i) begin
            m_el++;
            if (m_el == TO) begin m_div = 0; m_to = 1; end
        end
        @(posedge clk_100MHz);
        #1;
        chk("stall_cnt", {28'd0, stall_cnt_o}, m_stall);
        chk("flush_cnt", {28'd0, flush_cnt_o}, m_flush);
        chk("div_to",    {31'd0, div_timeout_o}, {31'd0, m_to});
    endtask

    // Asynchronous reset pulse with stall-causing inputs applied: outputs must drop immediately
    task automatic pulse_reset();
        mem_wait_i = 1; ex_jump_ena_i = 1; ex_jump_addr_i = 32'hDEAD_0000;
        #1 arst_n = 0;
        #1;
        chk("rst_hold",  {28'd0, hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o}, 0);
        chk("rst_flush", {29'd0, flush_if_id_o, flush_id_ex_o, flush_ex_mem_o}, 0);
        chk("rst_jena",  {31'd0, jump_ena_o}, 0);
        chk("rst_jaddr", jump_addr_o, 0);
        chk("rst_cnt",   {24'd0, stall_cnt_o, flush_cnt_o}, 0);
        chk("rst_to",    {31'd0, div_timeout_o}, 0);
        idle_inputs();
        model_clear();
        #1 arst_n = 1;
    endtask

    initial begin
        idle_inputs();
        model_clear();
        repeat (2) @(posedge clk_100MHz);
        #1 arst_n = 1;
        cycle();

        // Counter wrap: 17 stall cycles on a 4-bit counter
        mem_wait_i = 1;
        repeat (17) cycle();
        mem_wait_i = 0;
        chk("wrap", {28'd0, stall_cnt_o}, 1);
        pulse_reset();
        cycle();

        // Load-use on rs2, then same with x0 destination
        ex_mem_r_ena_i = 1; ex_reg_w_ena_i = 1; ex_reg_w_addr_i = 5;
        id_reg2_r_ena_i = 1; id_reg2_addr_i = 5;
        cycle();
        chk("lu_stall", {28'd0, stall_cnt_o}, 1);
        ex_reg_w_addr_i = 0; id_reg2_addr_i = 0;
        cycle();
        idle_inputs();
        cycle();

        // Plain jump
        ex_jump_ena_i = 1; ex_jump_addr_i = 32'h0000_0100;
        cycle();
        chk("jmp_cnt", {28'd0, flush_cnt_o}, 1);
        idle_inputs();

        // Jumps during memory wait: older one wins after wait ends
        mem_wait_i = 1; ex_jump_ena_i = 1; ex_jump_addr_i = 32'h200;
        cycle();
        ex_jump_addr_i = 32'h300;
        cycle();
        ex_jump_ena_i = 0;
        cycle();
        mem_wait_i = 0;
        cycle();
        chk("pend_cnt", {28'd0, flush_cnt_o}, 2);
        cycle();

        // Divide with done after 10 stall cycles
        ex_div_start_i = 1;
        cycle();
        ex_div_start_i = 0;
        repeat (10) cycle();
        div_done_i = 1;
        cycle();
        div_done_i = 0;
        cycle();

        // Divide watchdog, then confirm the flag stays set
        ex_div_start_i = 1;
        cycle();
        ex_div_start_i = 0;
        repeat (TO + 4) cycle();
        chk("to_sticky", {31'd0, div_timeout_o}, 1);

        // Reset in the middle of a divide with a pending jump
        ex_div_start_i = 1;
        cycle();
        ex_div_start_i = 0;
        repeat (3) cycle();
        mem_wait_i = 1; ex_jump_ena_i = 1; ex_jump_addr_i = 32'h440;
        cycle();
        pulse_reset();
        repeat (2) cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            id_reg1_r_ena_i = 1'($urandom);
            id_reg2_r_ena_i = 1'($urandom);
            id_reg1_addr_i  = 5'($urandom_range(0, 3));
            id_reg2_addr_i  = 5'($urandom_range(0, 3));
            ex_mem_r_ena_i  = 1'($urandom);
            ex_reg_w_ena_i  = 1'($urandom);
            ex_reg_w_addr_i = 5'($urandom_range(0, 3));
            ex_jump_ena_i   = ($urandom_range(0, 5) == 0);
            ex_jump_addr_i  = $urandom;
            ex_div_start_i  = ($urandom_range(0, 9) == 0);
            div_done_i      = ($urandom_range(0, 11) == 0);
            mem_wait_i      = ($urandom_range(0, 3) == 0);
            cycle();
            if (i == 1500) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
